active_devil_burst: RTL and testbench

//  Parametrised next-generation active-path engine: issues ACE read, write or read-modify-write

---
 rtl/active_devil_burst.sv | 213 +++++++++++++++++++++
 tb/tb_active_devil_burst.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/active_devil_burst.sv
// active_devil_burst
//   Active-path engine that runs ACE read, write or read-modify-write bursts
//   over a run of consecutive cache lines starting at a line-aligned base.
//   Each line is one AR/R (and/or AW/W/B) burst of C_LINE_BEATS beats. The
//   engine acknowledges each line with RACK or WACK. A bad response stops the
//   run at the end of the current line.
//
//   Optional feature macro: ACTIVE_DEVIL_RMW_EN
//     defined   : mode 2 reads a line, XORs it with i_tamper_mask and writes it back
//     undefined : mode 2 is illegal (o_err, straight to DONE, no bus traffic)
//
//   Ports
//     ace_aclk, ace_aresetn       clock, async active-low reset
//     i_start/i_mode/i_base_addr  command (sampled in IDLE only)
//     i_num_lines/i_wr_line       line count, write line data
//     i_tamper_mask               RMW XOR mask
//     o_busy/o_done/o_err         state!=IDLE, completion pulse, sticky error
//     o_line_idx/o_line_data      current line index, last line read
//     AR/R/AW/W/B channels        ACE master handshakes, o_rack/o_wack pulses
module active_devil_burst #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_ACE_ADDR_WIDTH = 44,
    parameter int C_LINE_BEATS     = 4,
    parameter int C_CNT_WIDTH      = 8
) (
    input  logic                                     ace_aclk,
    input  logic                                     ace_aresetn,
    input  logic                                     i_start,
    input  logic [1:0]                               i_mode,
    input  logic [C_ACE_ADDR_WIDTH-1:0]              i_base_addr,
    input  logic [C_CNT_WIDTH-1:0]                   i_num_lines,
    input  logic [C_ACE_DATA_WIDTH*C_LINE_BEATS-1:0] i_wr_line,
    input  logic [C_ACE_DATA_WIDTH*C_LINE_BEATS-1:0] i_tamper_mask,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err,
    output logic [C_CNT_WIDTH-1:0]                   o_line_idx,
    output logic [C_ACE_DATA_WIDTH*C_LINE_BEATS-1:0] o_line_data,
    output logic [C_ACE_ADDR_WIDTH-1:0]              o_araddr,
    output logic [7:0]                               o_arlen,
    output logic                                     o_arvalid,
    input  logic                                     i_arready,
    input  logic                                     i_rvalid,
    input  logic [C_ACE_DATA_WIDTH-1:0]              i_rdata,
    input  logic                                     i_rlast,
    input  logic [3:0]                               i_rresp,
    output logic                                     o_rready,
    output logic                                     o_rack,
    output logic [C_ACE_ADDR_WIDTH-1:0]              o_awaddr,
    output logic [7:0]                               o_awlen,
    output logic                                     o_awvalid,
    input  logic                                     i_awready,
    output logic [C_ACE_DATA_WIDTH-1:0]              o_wdata,
    output logic                                     o_wvalid,
    output logic                                     o_wlast,
    input  logic                                     i_wready,
    input  logic                                     i_bvalid,
    input  logic [1:0]                               i_bresp,
    output logic                                     o_bready,
    output logic                                     o_wack
);
    localparam int LINE_BYTES = C_LINE_BEATS * C_ACE_DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BIDX_W     = $clog2(C_LINE_BEATS);
    // one extra bit so the beat counter can saturate at C_LINE_BEATS
    localparam int BW         = BIDX_W + 1;
    localparam logic [BW-1:0] NBEATS    = BW'(C_LINE_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(C_LINE_BEATS - 1);

    localparam logic [1:0] MODE_RD  = 2'd0;
    localparam logic [1:0] MODE_WR  = 2'd1;
    localparam logic [1:0] MODE_RMW = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_AR, S_R, S_RACK, S_AW, S_W, S_B, S_WACK, S_NEXT, S_DONE
    } state_t;

    typedef logic [C_LINE_BEATS-1:0][C_ACE_DATA_WIDTH-1:0] line_t;

    state_t                      state_q, state_n;
    logic [1:0]                  mode_q;
    logic [C_ACE_ADDR_WIDTH-1:0] base_q;
    logic [C_CNT_WIDTH-1:0]      lines_q, idx_q, idx_nxt;
    logic [BW-1:0]               beat_q;
    logic                        err_q;
    line_t                       line_q, src_line;
    logic [C_ACE_ADDR_WIDTH-1:0] line_addr;
    logic                        mode_ok;

`ifdef ACTIVE_DEVIL_RMW_EN
    assign mode_ok  = (i_mode != 2'd3);
    assign src_line = (mode_q == MODE_RMW) ? (line_q ^ line_t'(i_tamper_mask)) : line_t'(i_wr_line);
    logic unused_in;
    assign unused_in = ^{i_base_addr[OFF_W-1:0], i_rresp[3:2], i_rresp[0]};
`else
    assign mode_ok  = (i_mode == MODE_RD) || (i_mode == MODE_WR);
    assign src_line = line_t'(i_wr_line);
    logic unused_in;
    assign unused_in = ^{i_tamper_mask, i_base_addr[OFF_W-1:0], i_rresp[3:2], i_rresp[0]};
`endif

    // address arithmetic wraps silently at 2^C_ACE_ADDR_WIDTH
    assign line_addr = base_q + (C_ACE_ADDR_WIDTH'(idx_q) << OFF_W);
    assign idx_nxt   = idx_q + C_CNT_WIDTH'(1);

    assign o_busy      = (state_q != S_IDLE);
    assign o_err       = err_q;
    assign o_line_idx  = idx_q;
    assign o_line_data = line_q;
    assign o_araddr    = line_addr;
    assign o_awaddr    = line_addr;
    assign o_arlen     = 8'(C_LINE_BEATS - 1);
    assign o_awlen     = 8'(C_LINE_BEATS - 1);

    always_comb begin
        state_n   = state_q;
        o_arvalid = 1'b0;
        o_rready  = 1'b0;
        o_rack    = 1'b0;
        o_awvalid = 1'b0;
        o_wvalid  = 1'b0;
        o_wlast   = 1'b0;
        o_wdata   = '0;
        o_bready  = 1'b0;
        o_wack    = 1'b0;
        o_done    = 1'b0;
        case (state_q)
            S_IDLE: if (i_start) begin
                if (i_num_lines == '0 || !mode_ok) state_n = S_DONE;
                else if (i_mode == MODE_WR)        state_n = S_AW;
                else                               state_n = S_AR;
            end
            S_AR: begin
                o_arvalid = 1'b1;
                if (i_arready) state_n = S_R;
            end
            S_R: begin
                o_rready = 1'b1;
                if (i_rvalid && i_rlast) state_n = S_RACK;
            end
            S_RACK: begin
                o_rack  = 1'b1;
                state_n = (mode_q == MODE_RMW) ? S_AW : S_NEXT;
            end
            S_AW: begin
                o_awvalid = 1'b1;
                if (i_awready) state_n = S_W;
            end
            S_W: begin
                o_wvalid = 1'b1;
                o_wdata  = src_line[beat_q[BIDX_W-1:0]];
                o_wlast  = (beat_q == LAST_BEAT);
                if (i_wready && o_wlast) state_n = S_B;
            end
            S_B: begin
                o_bready = 1'b1;
                if (i_bvalid) state_n = S_WACK;
            end
            S_WACK: begin
                o_wack  = 1'b1;
                state_n = S_NEXT;
            end
            S_NEXT: begin
                if (err_q || idx_nxt == lines_q) state_n = S_DONE;
                else if (mode_q == MODE_WR)      state_n = S_AW;
                else                             state_n = S_AR;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            base_q  <= '0;
            lines_q <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_n;
            case (state_q)
                S_IDLE: if (i_start) begin
                    err_q   <= !mode_ok;
                    mode_q  <= i_mode;
                    base_q  <= {i_base_addr[C_ACE_ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                    lines_q <= i_num_lines;
                    idx_q   <= '0;
                    beat_q  <= '0;
                end
                S_R: if (i_rvalid) begin
                    // beats beyond the line are dropped; counter saturates
                    if (beat_q < NBEATS) begin
                        line_q[beat_q[BIDX_W-1:0]] <= i_rdata;
                        beat_q <= beat_q + BW'(1);
                    end
                    if (i_rresp[1] || (i_rlast && beat_q != LAST_BEAT)) err_q <= 1'b1;
                    if (i_rlast) beat_q <= '0;
                end
                S_W: if (i_wready) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
                S_B: if (i_bvalid && i_bresp != 2'b00) err_q <= 1'b1;
                S_NEXT: idx_q <= idx_nxt;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_active_devil_burst.sv
module tb_active_devil_burst;
    localparam int DW = 128, AW = 44, NB = 4, CW = 8, LW = DW * NB;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 0;
    logic [1:0]    mode = 0;
    logic [AW-1:0] base = 0;
    logic [CW-1:0] nlines = 0;
    logic [LW-1:0] wr_line = 0, mask = 0;
    logic          busy, done, err;
    logic [CW-1:0] idx;
    logic [LW-1:0] line_data;
    logic [AW-1:0] araddr, awaddr;
    logic [7:0]    arlen, awlen;
    logic          arvalid, arready = 0, rvalid = 0, rlast = 0, rready, rack;
    logic [DW-1:0] rdata = 0, wdata;
    logic [3:0]    rresp = 0;
    logic          awvalid, awready = 0, wvalid, wlast, wready = 0;
    logic          bvalid = 0, bready, wack;
    logic [1:0]    bresp = 0;

    int checks = 0, failures = 0;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] wq[$];
    logic [LW-1:0] rd_q[$];

    always #5 clk = ~clk;

    active_devil_burst #(.C_ACE_DATA_WIDTH(DW), .C_ACE_ADDR_WIDTH(AW),
                         .C_LINE_BEATS(NB), .C_CNT_WIDTH(CW)) dut (
        .ace_aclk(clk), .ace_aresetn(rst_n), .i_start(start), .i_mode(mode),
        .i_base_addr(base), .i_num_lines(nlines), .i_wr_line(wr_line),
        .i_tamper_mask(mask), .o_busy(busy), .o_done(done), .o_err(err),
        .o_line_idx(idx), .o_line_data(line_data),
        .o_araddr(araddr), .o_arlen(arlen), .o_arvalid(arvalid), .i_arready(arready),
        .i_rvalid(rvalid), .i_rdata(rdata), .i_rlast(rlast), .i_rresp(rresp),
        .o_rready(rready), .o_rack(rack),
        .o_awaddr(awaddr), .o_awlen(awlen), .o_awvalid(awvalid), .i_awready(awready),
        .o_wdata(wdata), .o_wvalid(wvalid), .o_wlast(wlast), .i_wready(wready),
        .i_bvalid(bvalid), .i_bresp(bresp), .o_bready(bready), .o_wack(wack));

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit sig(input int w);
        case (w)
            0: return arvalid;
            1: return awvalid;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string tag);
        int n = 0;
        while (sig(w) !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_seen"}, LW'(sig(w)), 1);
    endtask

    task automatic go(input logic [1:0] m, input logic [AW-1:0] b, input logic [CW-1:0] n);
        mode = m; base = b; nlines = n; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // slave side of one read line; expected address and data come from the queues
    task automatic serve_read(input int err_beat);
        logic [AW-1:0] ea;
        logic [LW-1:0] d;
        wait_sig(0, "arvalid");
        ea = addr_q.pop_front();
        d  = rd_q.pop_front();
        chk("araddr", LW'(araddr), LW'(ea));
        chk("arlen", LW'(arlen), 3);
        chk("ar_aw_excl", LW'(awvalid), 0);
        arready = 1; @(negedge clk); arready = 0;
        chk("rready", LW'(rready), 1);
        for (int k = 0; k < NB; k++) begin
            rvalid = 1; rdata = d[DW*k +: DW]; rlast = (k == NB - 1);
            rresp = (k == err_beat) ? 4'h2 : 4'h0;
            @(negedge clk);
        end
        rvalid = 0; rlast = 0; rresp = 0;
        chk("rack", LW'(rack), 1);
        chk("line_data", line_data, d);
    endtask

    // slave side of one write line; wq holds the expected beats
    task automatic serve_write(input int stall_beat, input int stall_n, input logic [1:0] resp);
        logic [AW-1:0] ea;
        logic [DW-1:0] eb;
        wait_sig(1, "awvalid");
        ea = addr_q.pop_front();
        chk("awaddr", LW'(awaddr), LW'(ea));
        chk("awlen", LW'(awlen), 3);
        chk("aw_ar_excl", LW'(arvalid), 0);
        awready = 1; @(negedge clk); awready = 0;
        for (int k = 0; k < NB; k++) begin
            eb = wq.pop_front();
            if (k == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    wready = 0;
                    chk("wvalid_stall", LW'(wvalid), 1);
                    chk("wdata_stall", LW'(wdata), LW'(eb));
                    @(negedge clk);
                end
            end
            wready = 1;
            chk("wvalid", LW'(wvalid), 1);
            chk("wdata", LW'(wdata), LW'(eb));
            chk("wlast", LW'(wlast), LW'(k == NB - 1));
            @(negedge clk);
        end
        wready = 0;
        chk("bready", LW'(bready), 1);
        bvalid = 1; bresp = resp; @(negedge clk); bvalid = 0; bresp = 0;
        chk("wack", LW'(wack), 1);
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n = 0;
        bit trf = 0;
        while (done !== 1'b1 && n < 40) begin
            if (arvalid || awvalid) trf = 1;
            @(negedge clk); n++;
        end
        chk({tag, "_done"}, LW'(done), 1);
        chk({tag, "_err"}, LW'(err), LW'(exp_err));
        chk({tag, "_no_extra_traffic"}, LW'(trf), 0);
        @(negedge clk);
        chk({tag, "_idle"}, LW'(busy), 0);
    endtask

    task automatic push_line(input logic [LW-1:0] l);
        for (int k = 0; k < NB; k++) wq.push_back(l[DW*k +: DW]);
    endtask

    initial begin
        logic [LW-1:0] la, lb, lff;
        for (int i = 0; i < LW / 32; i++) begin la[32*i +: 32] = $urandom; lb[32*i +: 32] = $urandom; end
        lff = '1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", LW'(busy), 0);
        chk("rst_err", LW'(err), 0);
        chk("rst_done", LW'(done), 0);
        chk("rst_valids", LW'({arvalid, awvalid, wvalid, rready, bready, rack, wack}), 0);
        chk("rst_line_data", line_data, 0);
        rst_n = 1;
        @(negedge clk);

        // two-line read; low offset bits of the base are dropped
        addr_q.push_back(44'h1000_0000); addr_q.push_back(44'h1000_0040);
        rd_q.push_back(la); rd_q.push_back(lb);
        go(0, 44'h1000_003F, 2);
        chk("ar_latency", LW'(arvalid), 1);
        serve_read(-1);
        serve_read(-1);
        wait_done("read2", 0);

        // one-line write with wready stalled on beat 1
        wr_line = {128'hDDDD_0003, 128'hCCCC_0002, 128'hBBBB_0001, 128'hAAAA_0000};
        addr_q.push_back(44'h2000_0000);
        push_line(wr_line);
        go(1, 44'h2000_0000, 1);
        chk("aw_latency", LW'(awvalid), 1);
        serve_write(1, 2, 2'b00);
        wait_done("write1", 0);

        // read-modify-write
        mask = {64{8'h0F}};
`ifdef ACTIVE_DEVIL_RMW_EN
        addr_q.push_back(44'h3000_0080); addr_q.push_back(44'h3000_0080);
        rd_q.push_back(lff);
        push_line({64{8'hF0}});
        go(2, 44'h3000_0080, 1);
        serve_read(-1);
        serve_write(-1, 0, 2'b00);
        wait_done("rmw", 0);
`else
        go(2, 44'h3000_0080, 1);
        wait_done("rmw_illegal", 1);
`endif

        // SLVERR on line 0 of three aborts the run
        addr_q.push_back(44'h5000_0000);
        push_line(lb); wr_line = lb;
        go(1, 44'h5000_0000, 3);
        serve_write(-1, 0, 2'b10);
        wait_done("slverr", 1);

        // address wraps to 0; error from previous run is cleared by start
        addr_q.push_back(44'hFFF_FFFF_FFC0); addr_q.push_back(44'h0);
        wr_line = la; push_line(la); push_line(la);
        go(1, 44'hFFF_FFFF_FFC1, 2);
        chk("err_cleared", LW'(err), 0);
        serve_write(-1, 0, 2'b00);
        serve_write(-1, 0, 2'b00);
        wait_done("wrap", 0);

        // read error response on beat 2 aborts after line 0
        addr_q.push_back(44'h4000_0000); rd_q.push_back(la);
        go(0, 44'h4000_0000, 2);
        serve_read(2);
        wait_done("rresp_err", 1);

        // zero lines and illegal mode
        go(0, 44'h0, 0);
        wait_done("zero_lines", 0);
        go(3, 44'h0, 1);
        wait_done("mode3", 1);

        // reset in the middle of the R phase
        go(0, 44'h6000_0000, 1);
        wait_sig(0, "arvalid_mid");
        arready = 1; @(negedge clk); arready = 0;
        rvalid = 1; rdata = la[DW-1:0]; @(negedge clk);
        rst_n = 0; #1;
        chk("midrst_rready", LW'(rready), 0);
        chk("midrst_busy", LW'(busy), 0);
        chk("midrst_valids", LW'({arvalid, awvalid, wvalid, bready}), 0);
        chk("midrst_line", line_data, 0);
        rvalid = 0;
        @(negedge clk); rst_n = 1; @(negedge clk);
        addr_q.push_back(44'h6000_0000); rd_q.push_back(lb);
        go(0, 44'h6000_0000, 1);
        serve_read(-1);
        wait_done("after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
